aes_addroundkey_stage: RTL
==========================

// Module: aes_addroundkey_stage
// PURPOSE
//  Downstream neighbour of the MixColumns stage in the AES encrypt datapath. Joins
//  the 128-bit column-mixed state stream with the round-key stream, XORs them
//  (AddRoundKey), tags each result with its round index and buffers it in a small
//  output FIFO. Valid/ready on all three interfaces so key expansion can stall.
// PARAMETERS
//  NR     10  rounds per block (10/12/14 for AES-128/192/256); round tag range 1..NR
//  DEPTH  2   output FIFO entries; power of two, >=2
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    state word valid (from MixColumns, or ShiftRows on final round)
//  in_ready   out  1    stage accepts state word this cycle
//  in_data    in   128  state, column 0 in [127:96], byte 0 of column in MSB
//  in_last    in   1    this word is the block's final round (MixColumns bypassed)
//  key_valid  in   1    round key valid
//  key_ready  out  1    stage accepts round key this cycle
//  round_key  in   128  round key, same byte order as in_data
//  out_valid  out  1    FIFO head valid
//  out_ready  in   1    consumer takes head this cycle
//  out_data   out  128  in_data ^ round_key
//  out_round  out  4    round index of head word, 1..NR
//  out_last   out  1    head word is final round (ciphertext)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO emptied, count=0, rd/wr ptr=0, round ctr=1;
//    out_valid=0, out_data=0, out_round=0, out_last=0, in_ready=0, key_ready=0.
//  - Join: in_ready = !full & key_valid; key_ready = !full & in_valid. Push occurs
//    iff in_valid & key_valid & !full; both streams consumed in the same cycle.
//    No combinational path from out_ready to in_ready/key_ready.
//  - Full: count==DEPTH -> no push, even if a pop occurs the same cycle.
//  - Pop: out_valid & out_ready; head advances, rd ptr wraps mod DEPTH.
//  - Simultaneous push+pop with 0<count<DEPTH: count unchanged, both ptrs advance.
//  - Latency: push at edge N -> out_valid=1 after edge N (1 cycle) when FIFO empty;
//    throughput 1 word/cycle while consumer ready. Words leave in push order.
//  - out_data/out_round/out_last show FIFO head combinationally from storage;
//    hold stable while out_valid & !out_ready.
//  - Round counter: tag stored with pushed word = current ctr. On push: if in_last
//    ctr<=1; else if ctr==NR ctr<=1 (wrap); else ctr<=ctr+1.
//  - No data/key held across stall: upstream must hold values while valid & !ready.
//  - rst_n asserted mid-block: pending words discarded, next push tagged round 1.
// CONFIGURATION
//  ARK_SEQ_CHECK_EN defined: adds output seq_err (1 bit, reset 0, sticky until
//   rst_n). Set on a push where in_last=1 with ctr!=NR, or in_last=0 with ctr==NR.
//   The word is still pushed and the counter still updates as above.
//  Undefined: no seq_err port, no check logic; behaviour otherwise identical.
// TESTING
//  1 FIPS-197 B round1: in_data=046681e5e0cb199a48f8d37a2806264c, round_key=
//    a0fafe1788542cb123a339392a6c7605 -> out_data=a49c7ff2689f352b6b5bea43026a5049,
//    out_round=1, out_last=0, out_valid one cycle after push.
//  2 Full block NR=10: 9 words in_last=0 then 1 in_last=1, key=0 -> out_data==in_data,
//    out_round 1..10, out_last=1 only on 10th; next block starts at round 1.
//  3 Backpressure: out_ready=0, stream 3 words -> 2 accepted, in_ready/key_ready=0 while
//    full; raise out_ready -> words emerge in order, no loss/duplication.
//  4 Join stall: in_valid=1, key_valid=0 for 5 cycles -> no push, in_ready=0; key_valid=1
//    -> single push, both ready=1 that cycle.
//  5 Reset mid-block after round 4 with 1 word buffered -> out_valid=0 immediately,
//    next push tagged out_round=1.
//  6 ARK_SEQ_CHECK_EN: in_last=1 at round 3 -> seq_err=1 and stays 1; undefined build
//    compiles without seq_err and passes tests 1-5.

Source files
------------

// File: rtl/aes_addroundkey_stage.sv
// aes_addroundkey_stage
// AddRoundKey stage of the AES encrypt datapath. It joins the column-mixed
// state stream with the round-key stream and XORs them. Each result is tagged
// with its round index and the final-round flag, then buffered in a small
// output FIFO. All three interfaces use valid/ready handshakes.
// Optional feature: define ARK_SEQ_CHECK_EN to add a sticky seq_err output.
// That output flags a final-round marker that does not line up with the
// round counter.
module aes_addroundkey_stage #(
    parameter int NR    = 10,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   out_round,
    output logic         out_last
`ifdef ARK_SEQ_CHECK_EN
    ,
    output logic         seq_err
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [3:0]       round_ctr_reg;

    logic [127:0]     data_mem [DEPTH];
    logic [3:0]       round_mem [DEPTH];
    logic             last_mem [DEPTH];

    logic             full;
    logic             push;
    logic             pop;
    logic             ctr_at_nr;

    // Readiness depends only on registered occupancy and the opposite stream's
    // valid, so out_ready never reaches in_ready/key_ready. A full FIFO refuses
    // a push even when it is popped in the same cycle.
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign in_ready  = rst_n & ~full & key_valid;
    assign key_ready = rst_n & ~full & in_valid;
    assign push      = rst_n & in_valid & key_valid & ~full;
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign ctr_at_nr = (round_ctr_reg == 4'(NR));

    // The head is read straight from storage, so it holds while the consumer stalls.
    assign out_data  = data_mem[rd_ptr_reg];
    assign out_round = round_mem[rd_ptr_reg];
    assign out_last  = last_mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the keyed state word and its tags into this entry on a push.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_mem[gi]  <= '0;
                    round_mem[gi] <= '0;
                    last_mem[gi]  <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_mem[gi]  <= in_data ^ round_key;
                    round_mem[gi] <= round_ctr_reg;
                    last_mem[gi]  <= in_last;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Round tag counter. It restarts at 1 after a final-round word or after reaching NR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_ctr_reg <= 4'd1;
        end else if (push) begin
            if (in_last || ctr_at_nr) round_ctr_reg <= 4'd1;
            else                      round_ctr_reg <= round_ctr_reg + 4'd1;
        end
    end

`ifdef ARK_SEQ_CHECK_EN
    // Sticky flag for a final-round marker that disagrees with the round count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err <= 1'b0;
        end else if (push && (in_last != ctr_at_nr)) begin
            seq_err <= 1'b1;
        end
    end
`endif

endmodule
